// File: rtl/loader_pkg.sv
// Shared constants for the instruction-memory loader: frame sync byte,
// length-field width and FSM state encodings.
package loader_pkg;

    localparam int unsigned LEN_W        = 16;
    localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t LEN_LO = 3'd1;
    localparam state_t LEN_HI = 3'd2;
    localparam state_t DATA   = 3'd3;
    localparam state_t CSUM   = 3'd4;
    localparam state_t DONE   = 3'd5;
    localparam state_t ERR    = 3'd6;

endpackage

// File: rtl/word_assembler.sv
// Packs four consecutive bytes into a little-endian 32-bit word; word_valid_o
// pulses combinationally alongside the byte that completes the word.
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (byte_valid_i) begin
            // Shift right so the first byte of a word ends up in bits [7:0].
            shift_d = {byte_i, shift_q[23:8]};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);
    assign word_o       = {byte_i, shift_q};

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed host byte stream -> instruction memory writes; holds the CPU in reset
// until a frame with a matching XOR checksum has been loaded.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W        = 11,
    parameter logic [7:0]  SYNC          = SYNC_DEFAULT,
    parameter logic        HOLD_AT_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [LEN_W:0] CAPACITY = (LEN_W+1)'(1) << ADDR_W;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic [7:0]         csum_q, csum_d;
    logic               hold_q, hold_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               wren_q, wren_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic               asm_clear, asm_valid, asm_word_valid;
    logic [31:0]        asm_word;
    logic [LEN_W-1:0]   len_full;
    logic [ADDR_W:0]    cnt_next;
    logic               is_sync;

    assign len_full = {rx_data, len_q[7:0]};
    assign cnt_next = cnt_q + 1'b1;
    assign is_sync  = (rx_data == SYNC);

    word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_valid),
        .byte_i       (rx_data),
        .word_valid_o (asm_word_valid),
        .word_o       (asm_word)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        hold_d    = hold_q;
        done_d    = done_q;
        err_d     = err_q;
        wren_d    = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        asm_clear = 1'b0;
        asm_valid = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (rx_valid && is_sync) begin
                    state_d   = LEN_LO;
                    hold_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    csum_d    = 8'h00;
                    asm_clear = 1'b1;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    len_d   = {8'h00, rx_data};
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    len_d = len_full;
                    if ({1'b0, len_full} > CAPACITY) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else if (len_full == '0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                asm_valid = rx_valid;
                if (rx_valid) begin
                    csum_d = csum_q ^ rx_data;
                end
                if (asm_word_valid) begin
                    wren_d  = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = asm_word;
                    cnt_d   = cnt_next;
                    if ((LEN_W+1)'(cnt_next) == {1'b0, len_q}) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            csum_q  <= 8'h00;
            hold_q  <= HOLD_AT_RESET;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign rx_ready     = 1'b1;
    assign imem_wren    = wren_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a frame-position reference model checked
// every cycle, plus literal expectations for the hand-worked frames.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 11;
    localparam logic [7:0]  SYNC   = 8'hA5;
    localparam int          CAP    = 1 << ADDR_W;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              imem_wren;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .SYNC(SYNC), .HOLD_AT_RESET(1'b0)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_wren    (imem_wren),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks the byte position inside the current frame.
    bit          m_in_frame;
    int          m_pos;
    int          m_len;
    logic [7:0]  m_xor;
    logic [31:0] m_buf;
    bit          exp_wren;
    int          exp_addr;
    logic [31:0] exp_wdata;
    bit          exp_hold, exp_done, exp_err;
    int          exp_words;

    function automatic void model_reset();
        m_in_frame = 0; m_pos = 0; m_len = 0; m_xor = 8'h00; m_buf = '0;
        exp_wren = 0; exp_addr = 0; exp_wdata = '0;
        exp_hold = 0; exp_done = 0; exp_err = 0; exp_words = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [7:0] b);
        int d;
        exp_wren = 0;
        if (!v) return;
        if (!m_in_frame) begin
            if (b == SYNC) begin
                m_in_frame = 1; m_pos = 1; m_xor = 8'h00;
                exp_hold = 1; exp_done = 0; exp_err = 0; exp_words = 0;
            end
            return;
        end
        if (m_pos == 1) begin
            m_len = int'(b);
            m_pos = 2;
        end else if (m_pos == 2) begin
            m_len = m_len + 256 * int'(b);
            if (m_len > CAP) begin
                exp_err = 1;
                m_in_frame = 0;
            end else begin
                m_pos = 3;
            end
        end else begin
            d = m_pos - 3;
            if (d < 4 * m_len) begin
                m_xor = m_xor ^ b;
                m_buf[8*(d%4) +: 8] = b;
                if (d % 4 == 3) begin
                    exp_wren = 1; exp_addr = d / 4; exp_wdata = m_buf; exp_words = d / 4 + 1;
                end
                m_pos++;
            end else begin
                if (b == m_xor) begin exp_done = 1; exp_hold = 0; end
                else exp_err = 1;
                m_in_frame = 0;
            end
        end
    endfunction

    // Compare process and write log.
    int          cycle = 0;
    int          wr_count = 0;
    int          last_wr_cycle = 0;
    int          prev_wr_cycle = 0;
    logic [31:0] mem [0:CAP-1];

    always @(posedge clk) begin
        #1;
        cycle++;
        if (!rst) begin
            check("rx_ready", 64'(rx_ready), 64'(1));
            check("imem_wren", 64'(imem_wren), 64'(exp_wren));
            check("imem_addr", 64'(imem_addr), 64'(exp_addr));
            check("imem_wdata", 64'(imem_wdata), 64'(exp_wdata));
            check("cpu_hold", 64'(cpu_hold), 64'(exp_hold));
            check("load_done", 64'(load_done), 64'(exp_done));
            check("load_err", 64'(load_err), 64'(exp_err));
            check("words_loaded", 64'(words_loaded), 64'(exp_words));
            if (imem_wren) begin
                if (wr_count > 0) check("wr_spacing_ge4", 64'((cycle - last_wr_cycle) >= 4), 64'(1));
                prev_wr_cycle = last_wr_cycle;
                last_wr_cycle = cycle;
                wr_count++;
                mem[imem_addr] = imem_wdata;
            end
        end
    end

    task automatic drive(input bit v, input logic [7:0] b);
        @(negedge clk);
        rx_valid = v;
        rx_data  = b;
        @(posedge clk);
        if (!rst) model_step(v, b);
    endtask

    task automatic send(input logic [7:0] b, input int stall_pct);
        while ($urandom_range(99) < stall_pct) drive(1'b0, 8'($urandom));
        drive(1'b1, b);
    endtask

    task automatic send_frame(input bq_t f, input int stall_pct);
        foreach (f[i]) send(f[i], stall_pct);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'($urandom));
    endtask

    task automatic noise(input int n);
        logic [7:0] b;
        repeat (n) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h5A;
            drive(1'b1, b);
        end
    endtask

    function automatic bq_t make_frame(input int len, input bit good);
        bq_t f;
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        f.push_back(SYNC);
        f.push_back(8'(len));
        f.push_back(8'(len >> 8));
        for (int i = 0; i < 4 * len; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            f.push_back(b);
        end
        f.push_back(good ? x : (x ^ 8'h5A));
        return f;
    endfunction

    task automatic check_status(input string tag, input bit done, input bit err, input bit hold, input int words);
        check({tag, "_done"}, 64'(load_done), 64'(done));
        check({tag, "_err"}, 64'(load_err), 64'(err));
        check({tag, "_hold"}, 64'(cpu_hold), 64'(hold));
        check({tag, "_words"}, 64'(words_loaded), 64'(words));
    endtask

    initial begin
        bq_t good_f, bad_f, f;
        int  wr0;
        bit  good;
        int  len;

        good_f = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'hA0, 8'hE3,
                   8'h0A, 8'h10, 8'hA0, 8'hE3, 8'h1B};
        bad_f = good_f;
        bad_f[11] = 8'h00;
        model_reset();

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        check("rst_wren", 64'(imem_wren), 64'(0));
        check("rst_addr", 64'(imem_addr), 64'(0));
        check("rst_wdata", 64'(imem_wdata), 64'(0));
        check("rst_ready", 64'(rx_ready), 64'(1));
        check_status("rst", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Good frame, back-to-back.
        wr0 = wr_count;
        send_frame(good_f, 0);
        idle(2);
        check("good_wr_count", 64'(wr_count - wr0), 64'(2));
        check("good_wr_gap", 64'(last_wr_cycle - prev_wr_cycle), 64'(4));
        check("good_mem0", 64'(mem[0]), 64'h0000_0000_E3A0_0001);
        check("good_mem1", 64'(mem[1]), 64'h0000_0000_E3A0_100A);
        check_status("good", 1, 0, 0, 2);

        // Bad checksum, then recovery.
        wr0 = wr_count;
        send_frame(bad_f, 0);
        idle(2);
        check("bad_wr_count", 64'(wr_count - wr0), 64'(2));
        check_status("bad", 0, 1, 1, 2);
        send_frame(good_f, 0);
        idle(2);
        check_status("recover", 1, 0, 0, 2);

        // Zero length.
        wr0 = wr_count;
        send_frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 0);
        idle(2);
        check("zero_wr_count", 64'(wr_count - wr0), 64'(0));
        check_status("zero", 1, 0, 0, 0);

        // Oversize length (2049 words), then noise ignored.
        wr0 = wr_count;
        send_frame('{8'hA5, 8'h01, 8'h08}, 0);
        #2;
        check("over_err_next", 64'(load_err), 64'(1));
        noise(6);
        idle(1);
        check("over_wr_count", 64'(wr_count - wr0), 64'(0));
        check_status("over", 0, 1, 1, 0);

        // Reset mid-frame.
        wr0 = wr_count;
        for (int i = 0; i < 8; i++) send(good_f[i], 0);
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b0;
        #1;
        check("midrst_wr_before", 64'(wr_count - wr0), 64'(1));
        check("midrst_wren", 64'(imem_wren), 64'(0));
        check("midrst_addr", 64'(imem_addr), 64'(0));
        check_status("midrst", 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_no_write", 64'(wr_count - wr0), 64'(1));
        mem[0] = '0;
        mem[1] = '0;
        send_frame(good_f, 0);
        idle(2);
        check("after_rst_mem0", 64'(mem[0]), 64'h0000_0000_E3A0_0001);
        check("after_rst_mem1", 64'(mem[1]), 64'h0000_0000_E3A0_100A);
        check_status("after_rst", 1, 0, 0, 2);

        // Noise then stalled good frame.
        mem[0] = '0;
        mem[1] = '0;
        wr0 = wr_count;
        send(8'h00, 0); send(8'hFF, 0); send(8'h13, 0);
        send_frame(good_f, 50);
        idle(2);
        check("stall_wr_count", 64'(wr_count - wr0), 64'(2));
        check("stall_mem0", 64'(mem[0]), 64'h0000_0000_E3A0_0001);
        check("stall_mem1", 64'(mem[1]), 64'h0000_0000_E3A0_100A);
        check_status("stall", 1, 0, 0, 2);

        // Random frames with stalls and inter-frame noise.
        for (int n = 0; n < 8; n++) begin
            len  = $urandom_range(1, 9);
            good = 1'($urandom_range(1));
            f    = make_frame(len, good);
            noise($urandom_range(0, 3));
            send_frame(f, 30);
            idle(2);
            check_status("rand", good, !good, !good, len);
        end

        // Exact-capacity frame fills the whole memory.
        wr0 = wr_count;
        f = make_frame(CAP, 1'b1);
        send_frame(f, 0);
        idle(2);
        check("full_wr_count", 64'(wr_count - wr0), 64'(CAP));
        check("full_last_addr", 64'(imem_addr), 64'(CAP - 1));
        check_status("full", 1, 0, 0, CAP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
